// File: rtl/matrix_mult_pkg.sv
// Shared types for the matrix-multiply core and its tile scheduler.
// Holds the core config struct, the scheduler job/state types and default sizes.
package matrix_mult_pkg;

  localparam int DEF_ROW       = 4;
  localparam int DEF_COL       = 4;
  localparam int DEF_W_SIZE    = 256;
  localparam int DEF_I_SIZE    = 256;
  localparam int DEF_O_SIZE    = 256;
  localparam int DEF_MAX_TILES = 16;
  localparam int DEF_TIMEOUT   = 4096;

  localparam int W_AW   = $clog2(DEF_W_SIZE);
  localparam int I_AW   = $clog2(DEF_I_SIZE);
  localparam int O_AW   = $clog2(DEF_O_SIZE);
  localparam int TILE_W = $clog2(DEF_MAX_TILES) + 1;
  localparam int DIM_W  = 8;

  typedef struct packed {
    logic [W_AW-1:0]  w_offset;
    logic [I_AW-1:0]  i_offset;
    logic [O_AW-1:0]  psum_offset;
    logic [O_AW-1:0]  o_offset_w;
    logic [I_AW-1:0]  i_rows;
    logic [DIM_W-1:0] w_rows;
    logic [DIM_W-1:0] w_cols;
    logic             accum_en;
    logic [3:0]       extra_config;
  } data_config_struct;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [TILE_W-1:0] k_tiles;
    logic [TILE_W-1:0] n_tiles;
    logic [I_AW-1:0]   i_rows;
    logic [W_AW-1:0]   w_base;
    logic [I_AW-1:0]   i_base;
    logic [O_AW-1:0]   o_base;
  } tile_job_struct;

endpackage

// File: rtl/mm_tile_addr_gen.sv
// Per-pass core configuration from the current (k, n) tile and the latched job.
// All offsets wrap modulo their buffer depth.
module mm_tile_addr_gen
  import matrix_mult_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int COL    = DEF_COL,
  parameter int IDX_BW = $clog2(DEF_MAX_TILES)
) (
  input  logic [IDX_BW-1:0] k,
  input  logic [IDX_BW-1:0] n,
  input  tile_job_struct    job,
  output data_config_struct cfg
);

  logic [31:0] w_tile;
  logic [31:0] i_step;

  always_comb begin
    i_step = 32'(job.i_rows) + 32'd1;
    // Weight tiles are laid out n-major, each tile ROW words deep.
    w_tile = (32'(n) * 32'(job.k_tiles) + 32'(k)) * 32'(ROW);
    cfg              = '0;
    cfg.w_offset     = job.w_base + W_AW'(w_tile);
    cfg.i_offset     = job.i_base + I_AW'(32'(k) * i_step);
    cfg.psum_offset  = job.o_base + O_AW'(32'(n) * i_step);
    cfg.o_offset_w   = job.o_base + O_AW'(32'(n) * i_step);
    cfg.i_rows       = job.i_rows;
    cfg.w_rows       = DIM_W'(ROW - 1);
    cfg.w_cols       = DIM_W'(COL - 1);
    cfg.accum_en     = (k != '0);
    cfg.extra_config = '0;
  end

endmodule

// File: rtl/mm_tile_scheduler.sv
// Walks a tiled GEMM job (N outer, K inner) through the matrix-multiply core,
// one start/done pass per tile, with a done watchdog and abort.
module mm_tile_scheduler
  import matrix_mult_pkg::*;
#(
  parameter int ROW       = DEF_ROW,
  parameter int COL       = DEF_COL,
  parameter int W_SIZE    = DEF_W_SIZE,
  parameter int I_SIZE    = DEF_I_SIZE,
  parameter int O_SIZE    = DEF_O_SIZE,
  parameter int MAX_TILES = DEF_MAX_TILES,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                         clk_i,
  input  logic                         rstn_async_i,
  // Job handshake: a descriptor is taken on any cycle with job_valid_i && job_ready_o;
  // job_ready_o depends only on state, never on job_valid_i.
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [$clog2(MAX_TILES):0]   job_k_tiles_i,
  input  logic [$clog2(MAX_TILES):0]   job_n_tiles_i,
  input  logic [$clog2(I_SIZE)-1:0]    job_i_rows_i,
  input  logic [$clog2(W_SIZE)-1:0]    job_w_base_i,
  input  logic [$clog2(I_SIZE)-1:0]    job_i_base_i,
  input  logic [$clog2(O_SIZE)-1:0]    job_o_base_i,
  input  logic                         abort_i,
  output logic                         core_start_o,
  input  logic                         core_done_i,
  output data_config_struct            data_config_o,
  output logic                         busy_o,
  output logic                         job_done_o,
  output logic                         error_o,
  output logic [$clog2(MAX_TILES)-1:0] k_idx_o,
  output logic [$clog2(MAX_TILES)-1:0] n_idx_o,
  output sched_state_e                 state_o
);

  localparam int IDX_W = $clog2(MAX_TILES);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  sched_state_e      state_q, state_d;
  tile_job_struct    job_q, job_d;
  logic [IDX_W-1:0]  k_q, k_d, n_q, n_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              err_q, err_d;
  logic              last_k, last_n;
  data_config_struct cfg_q, cfg_calc;

  assign last_k = ({1'b0, k_q} == job_q.k_tiles - 1'b1);
  assign last_n = ({1'b0, n_q} == job_q.n_tiles - 1'b1);

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    k_d     = k_q;
    n_d     = n_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (job_valid_i) begin
        job_d.k_tiles = job_k_tiles_i;
        job_d.n_tiles = job_n_tiles_i;
        job_d.i_rows  = job_i_rows_i;
        job_d.w_base  = job_w_base_i;
        job_d.i_base  = job_i_base_i;
        job_d.o_base  = job_o_base_i;
        k_d     = '0;
        n_d     = '0;
        err_d   = 1'b0;
        // Empty jobs finish straight away without touching the core.
        state_d = (job_k_tiles_i == '0 || job_n_tiles_i == '0) ? DONE : CFG;
      end
      CFG:   state_d = START;
      START: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        if (core_done_i) begin
          state_d = NEXT;
        end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      NEXT: begin
        if (last_k) begin
          k_d     = '0;
          n_d     = n_q + 1'b1;
          state_d = last_n ? DONE : CFG;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = CFG;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE && state_q != DONE) begin
      state_d = DONE;
      err_d   = err_q;
    end
  end

  // Config is computed from next-state indices so it is valid on the first CFG cycle.
  mm_tile_addr_gen #(
    .ROW    (ROW),
    .COL    (COL),
    .IDX_BW (IDX_W)
  ) u_addr_gen (
    .k   (k_d),
    .n   (n_d),
    .job (job_d),
    .cfg (cfg_calc)
  );

  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      state_q <= IDLE;
      job_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      k_q     <= k_d;
      n_q     <= n_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (state_d == CFG) cfg_q <= cfg_calc;
    end
  end

  assign job_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign core_start_o  = (state_q == START) && !abort_i;
  assign job_done_o    = (state_q == DONE);
  assign error_o       = err_q;
  assign k_idx_o       = k_q;
  assign n_idx_o       = n_q;
  assign data_config_o = cfg_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Bench for mm_tile_scheduler: table of jobs with a per-pass config scoreboard,
// plus hand-written timeout, abort, busy-hold and mid-job reset sequences.
module tb_mm_tile_scheduler;
  import matrix_mult_pkg::*;

  localparam int EW = 41;

  logic              clk_i = 1'b0;
  logic              rstn_async_i = 1'b0;
  logic              job_valid_i = 1'b0;
  logic              job_ready_o;
  logic [4:0]        job_k_tiles_i = '0;
  logic [4:0]        job_n_tiles_i = '0;
  logic [7:0]        job_i_rows_i = '0;
  logic [7:0]        job_w_base_i = '0;
  logic [7:0]        job_i_base_i = '0;
  logic [7:0]        job_o_base_i = '0;
  logic              abort_i = 1'b0;
  logic              core_start_o;
  logic              core_done_i = 1'b0;
  data_config_struct data_config_o;
  logic              busy_o;
  logic              job_done_o;
  logic              error_o;
  logic [3:0]        k_idx_o;
  logic [3:0]        n_idx_o;
  sched_state_e      state_o;

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int core_cnt = 0;
  bit core_en = 1'b1;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  typedef struct {
    int k; int n; int rows; int wb; int ib; int ob;
  } vec_t;
  vec_t vecs[6];

  always #5 clk_i = ~clk_i;

  mm_tile_scheduler #(.TIMEOUT(16)) dut (
    .clk_i         (clk_i),
    .rstn_async_i  (rstn_async_i),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_k_tiles_i (job_k_tiles_i),
    .job_n_tiles_i (job_n_tiles_i),
    .job_i_rows_i  (job_i_rows_i),
    .job_w_base_i  (job_w_base_i),
    .job_i_base_i  (job_i_base_i),
    .job_o_base_i  (job_o_base_i),
    .abort_i       (abort_i),
    .core_start_o  (core_start_o),
    .core_done_i   (core_done_i),
    .data_config_o (data_config_o),
    .busy_o        (busy_o),
    .job_done_o    (job_done_o),
    .error_o       (error_o),
    .k_idx_o       (k_idx_o),
    .n_idx_o       (n_idx_o),
    .state_o       (state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [EW-1:0] exp_word(input int k, input int n, input int kt,
                                             input int rows, input int wb, input int ib,
                                             input int ob);
    logic [7:0] w, i, p;
    w = 8'(wb + (n * kt + k) * 4);
    i = 8'(ib + k * (rows + 1));
    p = 8'(ob + n * (rows + 1));
    return {w, i, p, p, 8'(rows), (k != 0)};
  endfunction

  task automatic push_model(input int kt, input int nt, input int rows, input int wb,
                            input int ib, input int ob);
    for (int n = 0; n < nt; n++)
      for (int k = 0; k < kt; k++)
        exp_q.push_back(exp_word(k, n, kt, rows, wb, ib, ob));
  endtask

  // Core model: done pulses 5 cycles after a start.
  always @(negedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      core_cnt = 0;
      core_done_i = 1'b0;
    end else begin
      core_done_i = 1'b0;
      if (core_cnt != 0) begin
        core_cnt--;
        if (core_cnt == 0) core_done_i = 1'b1;
      end
      if (core_start_o && core_en) core_cnt = 5;
    end
  end

  // Scoreboard: every start pulse pops one expected pass config.
  always @(negedge clk_i) begin
    if (rstn_async_i && core_start_o) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pass_cfg", 64'({data_config_o.w_offset, data_config_o.i_offset,
              data_config_o.psum_offset, data_config_o.o_offset_w,
              data_config_o.i_rows, data_config_o.accum_en}), 64'(mon_exp));
        check("pass_const", 64'({data_config_o.w_rows, data_config_o.w_cols,
              data_config_o.extra_config}), 64'({8'd3, 8'd3, 4'd0}));
      end
    end
  end

  task automatic send_job(input int k, input int n, input int rows, input int wb,
                          input int ib, input int ob);
    int b;
    b = 0;
    while (!job_ready_o && b < 200) begin
      @(negedge clk_i);
      b++;
    end
    check("ready_before_job", 64'(job_ready_o), 64'd1);
    job_valid_i   = 1'b1;
    job_k_tiles_i = 5'(k);
    job_n_tiles_i = 5'(n);
    job_i_rows_i  = 8'(rows);
    job_w_base_i  = 8'(wb);
    job_i_base_i  = 8'(ib);
    job_o_base_i  = 8'(ob);
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!job_done_o && cyc < limit) begin
      @(negedge clk_i);
      cyc++;
    end
    check("job_done_pulse", 64'(job_done_o), 64'd1);
    @(negedge clk_i);
    check("done_one_cycle", 64'(job_done_o), 64'd0);
    check("ready_after_job", 64'(job_ready_o), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(job_ready_o), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_start"}, 64'(core_start_o), 64'd0);
    check({tag, "_done"}, 64'(job_done_o), 64'd0);
    check({tag, "_error"}, 64'(error_o), 64'd0);
    check({tag, "_config"}, 64'(data_config_o), 64'd0);
    check({tag, "_idx"}, 64'({k_idx_o, n_idx_o}), 64'd0);
    check({tag, "_state"}, 64'(state_o), 64'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s0, seen, b;

    vecs[0] = '{k: 2,  n: 1, rows: 3, wb: 252,  ib: 0,    ob: 0};
    vecs[1] = '{k: 3,  n: 2, rows: 7, wb: 'h20, ib: 'hF0, ob: 'hFC};
    vecs[2] = '{k: 1,  n: 3, rows: 0, wb: 5,    ib: 1,    ob: 2};
    vecs[3] = '{k: 0,  n: 2, rows: 3, wb: 0,    ib: 0,    ob: 0};
    vecs[4] = '{k: 2,  n: 0, rows: 3, wb: 0,    ib: 0,    ob: 0};
    vecs[5] = '{k: 16, n: 1, rows: 1, wb: 'h80, ib: 0,    ob: 0};

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rstn_async_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("idle");

    // Reference 2x2 job with hand-derived pass configs.
    exp_q.push_back({8'h00, 8'h10, 8'h40, 8'h40, 8'd3, 1'b0});
    exp_q.push_back({8'h04, 8'h14, 8'h40, 8'h40, 8'd3, 1'b1});
    exp_q.push_back({8'h08, 8'h10, 8'h44, 8'h44, 8'd3, 1'b0});
    exp_q.push_back({8'h0C, 8'h14, 8'h44, 8'h44, 8'd3, 1'b1});
    s0 = n_starts;
    send_job(2, 2, 3, 0, 'h10, 'h40);
    wait_done(500, cyc);
    check("ref_latency", 64'(cyc), 64'd32);
    check("ref_starts", 64'(n_starts - s0), 64'd4);
    check("ref_queue", 64'(exp_q.size()), 64'd0);

    for (int v = 0; v < 6; v++) begin
      s0 = n_starts;
      push_model(vecs[v].k, vecs[v].n, vecs[v].rows, vecs[v].wb, vecs[v].ib, vecs[v].ob);
      send_job(vecs[v].k, vecs[v].n, vecs[v].rows, vecs[v].wb, vecs[v].ib, vecs[v].ob);
      wait_done(2000, cyc);
      check("vec_latency", 64'(cyc), 64'(8 * vecs[v].k * vecs[v].n));
      check("vec_starts", 64'(n_starts - s0), 64'(vecs[v].k * vecs[v].n));
      check("vec_error", 64'(error_o), 64'd0);
      check("vec_queue", 64'(exp_q.size()), 64'd0);
    end

    // Watchdog: no done from the core.
    core_en = 1'b0;
    s0 = n_starts;
    push_model(1, 1, 3, 0, 0, 0);
    send_job(1, 1, 3, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    check("to_in_wait", 64'(state_o), 64'(WAIT));
    repeat (15) @(negedge clk_i);
    check("to_error_early", 64'(error_o), 64'd0);
    @(negedge clk_i);
    check("to_error_set", 64'(error_o), 64'd1);
    check("to_done_pulse", 64'(job_done_o), 64'd1);
    @(negedge clk_i);
    check("to_ready", 64'(job_ready_o), 64'd1);
    check("to_error_sticky", 64'(error_o), 64'd1);
    check("to_starts", 64'(n_starts - s0), 64'd1);
    core_en = 1'b1;
    push_model(1, 1, 3, 0, 0, 0);
    send_job(1, 1, 3, 0, 0, 0);
    check("to_error_cleared", 64'(error_o), 64'd0);
    wait_done(200, cyc);

    // Abort in the WAIT of the second pass of a 3x3 job.
    s0 = n_starts;
    exp_q.push_back(exp_word(0, 0, 3, 3, 0, 0, 0));
    exp_q.push_back(exp_word(1, 0, 3, 3, 0, 0, 0));
    send_job(3, 3, 3, 0, 0, 0);
    seen = 0;
    b = 0;
    while (seen < 2 && b < 100) begin
      @(negedge clk_i);
      b++;
      if (core_start_o) seen++;
    end
    check("ab_second_start", 64'(seen), 64'd2);
    @(negedge clk_i);
    check("ab_k_idx", 64'(k_idx_o), 64'd1);
    abort_i = 1'b1;
    @(negedge clk_i);
    check("ab_done", 64'(job_done_o), 64'd1);
    check("ab_busy_in_done", 64'(busy_o), 64'd1);
    abort_i = 1'b0;
    @(negedge clk_i);
    check("ab_busy_dropped", 64'(busy_o), 64'd0);
    check("ab_error", 64'(error_o), 64'd0);
    repeat (8) @(negedge clk_i);
    check("ab_starts", 64'(n_starts - s0), 64'd2);
    check("ab_queue", 64'(exp_q.size()), 64'd0);

    // job_valid_i held while busy, then reset in the middle of WAIT.
    core_en = 1'b0;
    s0 = n_starts;
    push_model(1, 1, 3, 'h10, 'h20, 'h30);
    job_valid_i   = 1'b1;
    job_k_tiles_i = 5'd1;
    job_n_tiles_i = 5'd1;
    job_i_rows_i  = 8'd3;
    job_w_base_i  = 8'h10;
    job_i_base_i  = 8'h20;
    job_o_base_i  = 8'h30;
    repeat (6) @(negedge clk_i);
    check("hold_ready_low", 64'(job_ready_o), 64'd0);
    check("hold_state", 64'(state_o), 64'(WAIT));
    check("hold_starts", 64'(n_starts - s0), 64'd1);
    job_valid_i = 1'b0;
    #2;
    rstn_async_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk_i);
    rstn_async_i = 1'b1;
    core_en = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready", 64'(job_ready_o), 64'd1);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
